// File: rtl/ic_7475_pkg.sv
// ---------------------------------------------------------------------------
// ic7475_pkg
// Shared constants for the 7475 4-bit bistable latch replica.
//   RST_Q_DEFAULT : stored/output value applied while rst_n is low
//   Q1_IDX..Q4_IDX: bit positions of Q1..Q4 in the 4-bit state vector
//   PAIR_W        : width of one enable-sharing latch pair
// ---------------------------------------------------------------------------
package ic7475_pkg;

   localparam logic [3:0] RST_Q_DEFAULT = 4'b0000;

   localparam int Q1_IDX = 0;
   localparam int Q2_IDX = 1;
   localparam int Q3_IDX = 2;
   localparam int Q4_IDX = 3;

   localparam int PAIR_W = 2;

endpackage : ic7475_pkg

// File: rtl/ic_7475_latch_pair.sv
// ---------------------------------------------------------------------------
// latch_pair
// Two data bits sharing one active-high enable, emulated synchronously.
// A clk-edge register stores D while the enable is high; the output mux
// makes the pair transparent (Q = D) while enabled and returns the stored
// value once the enable drops.
//
// Parameters:
//   RST_V : value held in the store and forced on q while rst_n is low
// Ports:
//   clk   in  system clock, store updates on rising edge
//   rst_n in  asynchronous active-low reset
//   d     in  [PAIR_W-1:0] data
//   en    in  shared enable, active high
//   q     out [PAIR_W-1:0] latch outputs (combinational)
// ---------------------------------------------------------------------------
module latch_pair
   import ic7475_pkg::*;
#(
   parameter logic [PAIR_W-1:0] RST_V = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PAIR_W-1:0] d,
   input  logic              en,
   output logic [PAIR_W-1:0] q
);

   logic [PAIR_W-1:0] state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_V;
      end else if (en) begin
         state <= d;
      end
   end

   // Reset must win over the transparent path, otherwise a high enable
   // would leak D onto the pins while the chip is held in reset.
   always_comb begin
      q = state;
      if (!rst_n) begin
         q = RST_V;
      end else if (en) begin
         q = d;
      end
   end

endmodule : latch_pair

// File: rtl/ic_7475.sv
// ---------------------------------------------------------------------------
// ic_7475
// Clock-synchronous replica of the 7475 4-bit bistable latch. Pins keep the
// physical chip numbering. Bits 1-2 share enable p13, bits 3-4 share p4.
//
// Parameters:
//   RST_Q : reset value, bit0 = Q1 (p16) ... bit3 = Q4 (p9)
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   p2    in  D1        p3  in  D2        p6  in  D3        p7  in  D4
//   p13   in  enable bits 1-2 (active high)
//   p4    in  enable bits 3-4 (active high)
//   p16   out Q1        p15 out Q2        p10 out Q3        p9  out Q4
// Optional (macro IC7475_QBAR_EN):
//   p1 out ~Q1   p14 out ~Q2   p11 out ~Q3   p8 out ~Q4
// ---------------------------------------------------------------------------
module ic_7475
   import ic7475_pkg::*;
#(
   parameter logic [3:0] RST_Q = RST_Q_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic p2,
   input  logic p3,
   input  logic p6,
   input  logic p7,
   input  logic p13,
   input  logic p4,
   output logic p16,
   output logic p15,
   output logic p10,
   output logic p9
`ifdef IC7475_QBAR_EN
   ,
   output logic p1,
   output logic p14,
   output logic p11,
   output logic p8
`endif
);

   logic [3:0] d_all;
   logic [3:0] q_all;

   always_comb begin
      d_all         = '0;
      d_all[Q1_IDX] = p2;
      d_all[Q2_IDX] = p3;
      d_all[Q3_IDX] = p6;
      d_all[Q4_IDX] = p7;
   end

   latch_pair #(
      .RST_V (RST_Q[Q2_IDX:Q1_IDX])
   ) u_pair_12 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d_all[Q2_IDX:Q1_IDX]),
      .en    (p13),
      .q     (q_all[Q2_IDX:Q1_IDX])
   );

   latch_pair #(
      .RST_V (RST_Q[Q4_IDX:Q3_IDX])
   ) u_pair_34 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d_all[Q4_IDX:Q3_IDX]),
      .en    (p4),
      .q     (q_all[Q4_IDX:Q3_IDX])
   );

   assign p16 = q_all[Q1_IDX];
   assign p15 = q_all[Q2_IDX];
   assign p10 = q_all[Q3_IDX];
   assign p9  = q_all[Q4_IDX];

`ifdef IC7475_QBAR_EN
   // Complements come from the muxed Q, so during reset they read ~RST_Q.
   assign p1  = ~q_all[Q1_IDX];
   assign p14 = ~q_all[Q2_IDX];
   assign p11 = ~q_all[Q3_IDX];
   assign p8  = ~q_all[Q4_IDX];
`endif

endmodule : ic_7475

// File: tb/tb_ic_7475.sv
module tb_ic_7475;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] d = 4'b0000;
   logic       en12 = 1'b0;
   logic       en34 = 1'b0;

   logic p16, p15, p10, p9;
`ifdef IC7475_QBAR_EN
   logic p1, p14, p11, p8;
`endif

   always #5 clk = ~clk;

   ic_7475 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .p2    (d[0]),
      .p3    (d[1]),
      .p6    (d[2]),
      .p7    (d[3]),
      .p13   (en12),
      .p4    (en34),
      .p16   (p16),
      .p15   (p15),
      .p10   (p10),
      .p9    (p9)
`ifdef IC7475_QBAR_EN
      ,
      .p1    (p1),
      .p14   (p14),
      .p11   (p11),
      .p8    (p8)
`endif
   );

   // Reference model: value captured at the last enabled rising edge.
   logic [3:0] mdl_store;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_store <= 4'b0000;
      end else begin
         if (en12) mdl_store[1:0] <= d[1:0];
         if (en34) mdl_store[3:2] <= d[3:2];
      end
   end

   function automatic logic [3:0] model_q();
      logic [3:0] r;
      if (!rst_n) begin
         r = 4'b0000;
      end else begin
         r[1:0] = en12 ? d[1:0] : mdl_store[1:0];
         r[3:2] = en34 ? d[3:2] : mdl_store[3:2];
      end
      return r;
   endfunction

   logic [3:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Drive inputs between edges, push the expectation, then pop and compare
   // the combinational outputs before any clock edge can intervene.
   task automatic drive(input string tag, input logic r, input logic [3:0] dv,
                        input logic e12, input logic e34);
      logic [3:0] e;
      rst_n = r;
      d     = dv;
      en12  = e12;
      en34  = e34;
      #1;
      exp_q.push_back(model_q());
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_noexp"}, 4'b0000, 4'b1111);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {p9, p10, p15, p16}, e);
`ifdef IC7475_QBAR_EN
         chk({tag, "_qbar"}, {p8, p11, p14, p1}, ~e);
`endif
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic [3:0] dv,
                      input logic e12, input logic e34);
      @(negedge clk);
      drive(tag, r, dv, e12, e34);
   endtask

   logic [3:0] pat[5];

   initial begin
      pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0011;
      pat[3] = 4'b0100; pat[4] = 4'b1010;

      // Reset with everything high: outputs must stay at RST_Q.
      cyc("reset", 1'b0, 4'b1111, 1'b1, 1'b1);
      chk("reset_const", {p9, p10, p15, p16}, 4'b0000);
      cyc("reset2", 1'b0, 4'b1111, 1'b1, 1'b1);

      // Transparency straight after release, no clock edge between drive and check.
      cyc("transp_0001", 1'b1, 4'b0001, 1'b1, 1'b1);
      chk("transp_const", {p9, p10, p15, p16}, 4'b0001);
      cyc("transp_0010", 1'b1, 4'b0010, 1'b1, 1'b1);
      cyc("transp_0011", 1'b1, 4'b0011, 1'b1, 1'b1);

      // Hold: capture 0101, drop enables, change D.
      cyc("hold_load", 1'b1, 4'b0101, 1'b1, 1'b1);
      cyc("hold_drop", 1'b1, 4'b0101, 1'b0, 1'b0);
      cyc("hold_dchg", 1'b1, 4'b1010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc("hold_keep", 1'b1, 4'b1010, 1'b0, 1'b0);
      chk("hold_const", {p9, p10, p15, p16}, 4'b0101);

      // Independent pairs.
      cyc("indep_clr34", 1'b1, 4'b0000, 1'b0, 1'b1);
      cyc("indep_12on", 1'b1, 4'b1111, 1'b1, 1'b0);
      chk("indep_12_const", {p9, p10, p15, p16}, 4'b0011);
      cyc("indep_swap", 1'b1, 4'b1111, 1'b0, 1'b1);
      chk("indep_swap_const", {p9, p10, p15, p16}, 4'b1111);
      cyc("indep_swap2", 1'b1, 4'b0000, 1'b0, 1'b1);
      chk("indep_hold12", {p9, p10, p15, p16}, 4'b0011);

      // Toggling enables against the model.
      for (int c = 0; c < 50; c++) begin
         cyc("toggle", 1'b1, pat[(c / 2) % 5], ((c / 5) % 2) == 0, ((c / 5) % 2) == 0);
      end
      // Staggered enables: pairs out of phase.
      for (int c = 0; c < 30; c++) begin
         cyc("stagger", 1'b1, pat[(c / 3) % 5], ((c / 4) % 2) == 0, ((c / 7) % 2) == 1);
      end

      // Async reset during hold, asserted between edges.
      cyc("ar_load", 1'b1, 4'b1111, 1'b1, 1'b1);
      cyc("ar_hold", 1'b1, 4'b0000, 1'b0, 1'b0);
      chk("ar_hold_const", {p9, p10, p15, p16}, 4'b1111);
      @(posedge clk);
      #2;
      drive("ar_assert", 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("ar_const", {p9, p10, p15, p16}, 4'b0000);
      cyc("ar_release", 1'b1, 4'b0110, 1'b0, 1'b0);
      cyc("ar_after", 1'b1, 4'b0110, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_ic_7475
